// File: rtl/flp2b_pkg.sv
// Shared types and helpers for the fixed-length packet to byte stream converter.
package flp2b_pkg;

  // Framing state: waiting for a start-of-packet, or inside a packet.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BYTES_PER_WORD       = 4;
  localparam int DEFAULT_PACKET_BYTES = 256;

  // Number of valid bytes in a word; empty only counts on the EOP beat.
  function automatic logic [2:0] nbytes_of(input logic eop, input logic [1:0] empty);
    return eop ? (3'(BYTES_PER_WORD) - {1'b0, empty}) : 3'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/flp2b_word_shifter.sv
// Holding register for one 32-bit word, emitted MSB byte first.
// Optional byte-level framing outputs are enabled by FLP2B_SOP_EOP_OUT_EN.
module flp2b_word_shifter (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic [2:0]  i_nbytes,
`ifdef FLP2B_SOP_EOP_OUT_EN
  input  logic        i_sop_mark,
  input  logic        i_eop_mark,
  output logic        o_sop,
  output logic        o_eop,
`endif
  input  logic        i_out_ready,
  output logic        o_in_ready,
  output logic [7:0]  o_data,
  output logic        o_valid
);

  logic [31:0] r_data;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        w_xfer;
  logic        w_last_xfer;

  assign w_xfer      = r_valid & i_out_ready;
  assign w_last_xfer = w_xfer & (r_cnt == 3'd1);

  // NOTE: the sink is held off while reset is asserted; the register-empty
  // term alone would report ready during reset.
  assign o_in_ready = ~reset_reset & (~r_valid | w_last_xfer);
  assign o_data     = r_data[31:24];
  assign o_valid    = r_valid;

  // Load a new word (may coincide with draining the last byte) or shift one byte out.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_data  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      // NOTE: non-blocking assignments keep every register update tied to the
      // pre-edge values, so drain and reload in one cycle cannot race.
      r_data  <= i_data;
      r_cnt   <= i_nbytes;
      r_valid <= (i_nbytes != 3'd0);
    end else if (w_xfer) begin
      r_data  <= {r_data[23:0], 8'h00};
      r_cnt   <= r_cnt - 3'd1;
      r_valid <= (r_cnt != 3'd1);
    end
  end

`ifdef FLP2B_SOP_EOP_OUT_EN
  logic r_sop;
  logic r_eop;
  logic r_eop_word;

  assign o_sop = r_sop;
  assign o_eop = r_eop;

  // Byte framing flags follow the same load/shift/hold timing as the data.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
      r_eop_word <= 1'b0;
    end else if (i_load) begin
      r_sop      <= i_sop_mark;
      r_eop_word <= i_eop_mark;
      r_eop      <= i_eop_mark & (i_nbytes == 3'd1);
    end else if (w_xfer) begin
      r_sop      <= 1'b0;
      r_eop      <= r_eop_word & (r_cnt == 3'd2);
    end
  end
`endif

endmodule

// File: rtl/fix_length_packets2bytes.sv
// Fixed-length Avalon-ST packet (32-bit words) to 8-bit byte stream converter
// with framing checks reported on frame_err.
// Define FLP2B_SOP_EOP_OUT_EN to add byte-level SOP/EOP outputs.
module fix_length_packets2bytes
  import flp2b_pkg::*;
#(
  parameter int PACKET_BYTES = DEFAULT_PACKET_BYTES,
  parameter int CNT_W        = 13
) (
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic [31:0] asi_in0_data,
  input  logic        asi_in0_valid,
  output logic        asi_in0_ready,
  input  logic        asi_in0_startofpacket,
  input  logic        asi_in0_endofpacket,
  input  logic [1:0]  asi_in0_empty,
  output logic [7:0]  aso_out0_data,
  output logic        aso_out0_valid,
  input  logic        aso_out0_ready,
`ifdef FLP2B_SOP_EOP_OUT_EN
  output logic        aso_out0_startofpacket,
  output logic        aso_out0_endofpacket,
`endif
  output logic        frame_err
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_frame_err;

  logic             w_accept;
  logic             w_keep;
  logic             w_load;
  logic             w_len_done;
  logic             w_end;
  logic             w_err;
  logic [2:0]       w_nbytes;
  logic [CNT_W-1:0] w_base;
  logic [CNT_W-1:0] w_sum;

  assign w_accept = asi_in0_valid & asi_in0_ready;
  assign w_nbytes = nbytes_of(asi_in0_endofpacket, asi_in0_empty);

  // Words outside a packet are dropped unless they open a new one.
  assign w_keep = (r_state == RUN) | asi_in0_startofpacket;
  assign w_load = w_accept & w_keep;

  // A SOP word always restarts the count, including when it truncates a packet.
  assign w_base     = ((r_state == RUN) && !asi_in0_startofpacket) ? r_cnt : '0;
  assign w_sum      = w_base + CNT_W'(w_nbytes);
  assign w_len_done = (w_sum == CNT_W'(PACKET_BYTES));
  assign w_end      = asi_in0_endofpacket | w_len_done;

  // Violations: stray word, SOP inside a packet, EOP and length disagreeing.
  assign w_err = w_accept & (~w_keep
                           | ((r_state == RUN) & asi_in0_startofpacket)
                           | (asi_in0_endofpacket ^ w_len_done));

  assign frame_err = r_frame_err;

  // Framing FSM, packet byte counter and registered error pulse.
  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_err;
      if (w_load) begin
        if (w_end) begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end else begin
          r_state <= RUN;
          r_cnt   <= w_sum;
        end
      end
    end
  end

  flp2b_word_shifter u_shifter (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .i_load      (w_load),
    .i_data      (asi_in0_data),
    .i_nbytes    (w_nbytes),
`ifdef FLP2B_SOP_EOP_OUT_EN
    .i_sop_mark  (asi_in0_startofpacket),
    .i_eop_mark  (w_end),
    .o_sop       (aso_out0_startofpacket),
    .o_eop       (aso_out0_endofpacket),
`endif
    .i_out_ready (aso_out0_ready),
    .o_in_ready  (asi_in0_ready),
    .o_data      (aso_out0_data),
    .o_valid     (aso_out0_valid)
  );

endmodule

// File: tb/tb_fix_length_packets2bytes.sv
// Directed self-checking bench for fix_length_packets2bytes.
// With FLP2B_SOP_EOP_OUT_EN defined it also checks the byte SOP/EOP outputs.
module tb_fix_length_packets2bytes;

  logic        clock_clk;
  logic        reset_reset;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_ready;
  logic        asi_in0_startofpacket;
  logic        asi_in0_endofpacket;
  logic [1:0]  asi_in0_empty;
  logic [7:0]  aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_ready;
  logic        frame_err;
`ifdef FLP2B_SOP_EOP_OUT_EN
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;
`endif

  fix_length_packets2bytes dut (
    .clock_clk             (clock_clk),
    .reset_reset           (reset_reset),
    .asi_in0_data          (asi_in0_data),
    .asi_in0_valid         (asi_in0_valid),
    .asi_in0_ready         (asi_in0_ready),
    .asi_in0_startofpacket (asi_in0_startofpacket),
    .asi_in0_endofpacket   (asi_in0_endofpacket),
    .asi_in0_empty         (asi_in0_empty),
    .aso_out0_data         (aso_out0_data),
    .aso_out0_valid        (aso_out0_valid),
    .aso_out0_ready        (aso_out0_ready),
`ifdef FLP2B_SOP_EOP_OUT_EN
    .aso_out0_startofpacket(aso_out0_startofpacket),
    .aso_out0_endofpacket  (aso_out0_endofpacket),
`endif
    .frame_err             (frame_err)
  );

  initial clock_clk = 1'b0;
  always #5 clock_clk = ~clock_clk;

  // Source-ready: either forced by the sequence or toggling every cycle.
  logic toggle_en = 1'b0;
  logic tog       = 1'b1;
  logic rdy_force = 1'b1;
  assign aso_out0_ready = toggle_en ? tog : rdy_force;
  always @(posedge clock_clk) begin
    #1;
    tog = ~tog;
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int to_cnt       = 0;

  // Cycle counter and output monitor (sampled on the falling edge).
  int         cyc = 0;
  logic [7:0] got_q[$];
  int         got_cyc[$];
  logic       got_sop[$];
  logic       got_eop[$];
  int         err_cnt = 0;
  int         stall_seen = 0;
  int         stall_bad = 0;
  int         rdy_bad = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;
  int         first_accept_cyc = -1;
  int         first_valid_cyc = -1;

  always @(posedge clock_clk) cyc <= cyc + 1;

  always @(negedge clock_clk) begin
    if (reset_reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (aso_out0_valid && aso_out0_ready) begin
        got_q.push_back(aso_out0_data);
        got_cyc.push_back(cyc);
`ifdef FLP2B_SOP_EOP_OUT_EN
        got_sop.push_back(aso_out0_startofpacket);
        got_eop.push_back(aso_out0_endofpacket);
`endif
      end
      if (frame_err) err_cnt <= err_cnt + 1;
      if (aso_out0_valid && !aso_out0_ready) stall_seen <= stall_seen + 1;
      if (prev_stall && !(aso_out0_valid && aso_out0_data == prev_data))
        stall_bad <= stall_bad + 1;
      prev_stall <= aso_out0_valid && !aso_out0_ready;
      prev_data  <= aso_out0_data;
      // Sink may only be ready while holding data if the last byte is leaving.
      if (asi_in0_ready && aso_out0_valid && !aso_out0_ready) rdy_bad <= rdy_bad + 1;
      if (asi_in0_valid && asi_in0_ready && first_accept_cyc < 0) first_accept_cyc <= cyc;
      if (aso_out0_valid && first_valid_cyc < 0) first_valid_cyc <= cyc;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic align();
    @(posedge clock_clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded wait).
  task automatic send_word(input logic [31:0] d, input logic sop, input logic eop,
                           input logic [1:0] emp);
    int waited;
    waited = 0;
    asi_in0_data          = d;
    asi_in0_startofpacket = sop;
    asi_in0_endofpacket   = eop;
    asi_in0_empty         = emp;
    asi_in0_valid         = 1'b1;
    @(negedge clock_clk);
    while (!asi_in0_ready && waited < 200) begin
      @(negedge clock_clk);
      waited++;
    end
    if (waited >= 200) to_cnt++;
    @(posedge clock_clk);
    #1;
    asi_in0_valid         = 1'b0;
    asi_in0_startofpacket = 1'b0;
    asi_in0_endofpacket   = 1'b0;
    asi_in0_empty         = 2'd0;
  endtask

  // Word w carries bytes 4w..4w+3, first byte in the MSBs.
  task automatic send_packet(input int nw, input logic with_sop, input logic with_eop,
                             input logic [1:0] emp);
    logic [31:0] d;
    for (int w = 0; w < nw; w++) begin
      d = {8'(4 * w), 8'(4 * w + 1), 8'(4 * w + 2), 8'(4 * w + 3)};
      send_word(d, with_sop && (w == 0), with_eop && (w == nw - 1),
                (w == nw - 1) ? emp : 2'd0);
    end
  endtask

  task automatic wait_bytes(input int target, input int limit);
    int n;
    n = 0;
    while (got_q.size() < target && n < limit) begin
      @(negedge clock_clk);
      #1;
      n++;
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clock_clk);
    #1;
  endtask

  task automatic check_bytes(input string tag, input int start, input int n);
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(got_q[start + i]), 32'(i % 256));
  endtask

  task automatic check_marks(input string tag, input int start, input int n);
`ifdef FLP2B_SOP_EOP_OUT_EN
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_sop%0d", tag, i), 32'(got_sop[start + i]), 32'(i == 0));
      check($sformatf("%s_eop%0d", tag, i), 32'(got_eop[start + i]), 32'(i == n - 1));
    end
`endif
  endtask

  int s;
  int e;
  int sb;
  int rb;
  int ss;

  initial begin
    reset_reset           = 1'b1;
    asi_in0_data          = '0;
    asi_in0_valid         = 1'b0;
    asi_in0_startofpacket = 1'b0;
    asi_in0_endofpacket   = 1'b0;
    asi_in0_empty         = 2'd0;

    // Reset state
    repeat (3) @(negedge clock_clk);
    check("rst_out_valid", 32'(aso_out0_valid), 0);
    check("rst_out_data", 32'(aso_out0_data), 0);
    check("rst_in_ready", 32'(asi_in0_ready), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    reset_reset = 1'b0;
    @(negedge clock_clk);
    check("idle_in_ready", 32'(asi_in0_ready), 1);

    // 1: full packet, sink always ready
    s = got_q.size(); e = err_cnt; rb = rdy_bad;
    align();
    send_packet(64, 1'b1, 1'b1, 2'd0);
    wait_bytes(s + 256, 2000);
    settle();
    check("t1_count", got_q.size() - s, 256);
    check_bytes("t1", s, 256);
    check_marks("t1", s, 256);
    check("t1_latency", first_valid_cyc - first_accept_cyc, 1);
    check("t1_span", got_cyc[s + 255] - got_cyc[s], 255);
    check("t1_frame_err", err_cnt - e, 0);
    check("t1_ready_rule", rdy_bad - rb, 0);

    // 2: same packet with the sink toggling ready every cycle
    s = got_q.size(); e = err_cnt; sb = stall_bad; rb = rdy_bad; ss = stall_seen;
    align();
    toggle_en = 1'b1;
    send_packet(64, 1'b1, 1'b1, 2'd0);
    wait_bytes(s + 256, 4000);
    @(posedge clock_clk);
    #2;
    toggle_en = 1'b0;
    settle();
    check("t2_count", got_q.size() - s, 256);
    check_bytes("t2", s, 256);
    check("t2_stalls_seen", 32'(stall_seen - ss > 100), 1);
    check("t2_hold_stable", stall_bad - sb, 0);
    check("t2_ready_rule", rdy_bad - rb, 0);
    check("t2_frame_err", err_cnt - e, 0);

    // 3: early EOP on word 10 with empty=2, then a normal packet
    s = got_q.size(); e = err_cnt;
    align();
    send_packet(11, 1'b1, 1'b1, 2'd2);
    wait_bytes(s + 42, 500);
    settle();
    check("t3_count", got_q.size() - s, 42);
    check_bytes("t3", s, 42);
    check_marks("t3", s, 42);
    check("t3_frame_err", err_cnt - e, 1);
    s = got_q.size(); e = err_cnt;
    align();
    send_packet(64, 1'b1, 1'b1, 2'd0);
    wait_bytes(s + 256, 2000);
    settle();
    check("t3_next_count", got_q.size() - s, 256);
    check_bytes("t3_next", s, 256);
    check("t3_next_frame_err", err_cnt - e, 0);

    // 4: stray word in IDLE
    s = got_q.size(); e = err_cnt;
    align();
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
    settle();
    check("t4_count", got_q.size() - s, 0);
    check("t4_frame_err_cycles", err_cnt - e, 1);

    // 5: 64 words with no EOP, then two stray words
    s = got_q.size(); e = err_cnt;
    align();
    send_packet(64, 1'b1, 1'b0, 2'd0);
    send_word(32'hDEADBEEF, 1'b0, 1'b0, 2'd0);
    send_word(32'hCAFEF00D, 1'b0, 1'b0, 2'd0);
    wait_bytes(s + 256, 2000);
    settle();
    check("t5_count", got_q.size() - s, 256);
    check_bytes("t5", s, 256);
    check_marks("t5", s, 256);
    check("t5_frame_err", err_cnt - e, 3);

    // 6: reset while byte 100 is presented, then a fresh packet
    s = got_q.size(); e = err_cnt;
    align();
    send_packet(26, 1'b1, 1'b0, 2'd0);
    check("t6_valid_before_rst", 32'(aso_out0_valid), 1);
    check("t6_data_before_rst", 32'(aso_out0_data), 32'd100);
    reset_reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(aso_out0_valid), 0);
    check("t6_rst_data", 32'(aso_out0_data), 0);
    check("t6_rst_in_ready", 32'(asi_in0_ready), 0);
    check("t6_rst_frame_err", 32'(frame_err), 0);
    @(negedge clock_clk);
    reset_reset = 1'b0;
    settle();
    check("t6_partial_count", got_q.size() - s, 100);
    check_bytes("t6_partial", s, 100);
    s = got_q.size();
    align();
    send_packet(64, 1'b1, 1'b1, 2'd0);
    wait_bytes(s + 256, 2000);
    settle();
    check("t6_count", got_q.size() - s, 256);
    check_bytes("t6", s, 256);
    check_marks("t6", s, 256);
    check("t6_frame_err", err_cnt - e, 0);

    check("accept_timeouts", to_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
